// File: rtl/hc_mmio_initiator.sv
// MMIO command initiator: issues one read or write at a time,
// tracks the read tid, times out reads and counts stray responses.
module hc_mmio_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_LIMIT     = 'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        cmd_ready,
  output logic        mmio_wr_valid,
  output logic        mmio_rd_valid,
  output logic [15:0] mmio_addr,
  output logic [8:0]  mmio_tid,
  output logic [63:0] mmio_data,
  input  logic        rsp_valid,
  input  logic [8:0]  rsp_tid,
  input  logic [63:0] rsp_data,
  output logic        res_valid,
  output logic [63:0] res_data,
  output logic [1:0]  res_err,
  output logic [7:0]  stray_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic        oor_q, oor_d;
  logic [15:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [8:0]  mtid_q, mtid_d;
  logic [8:0]  tid_q, tid_d;
  logic [15:0] to_q, to_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rerr_q, rerr_d;
  logic [7:0]  stray_q, stray_d;
  logic        cmd_oor;

  assign cmd_oor   = 32'(cmd_addr) >= ADDR_LIMIT;
  assign mmio_addr = addr_q;
  assign mmio_data = data_q;
  assign mmio_tid  = mtid_q;
  assign res_data  = rdata_q;
  assign res_err   = rerr_q;
  assign stray_cnt = stray_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mtid_q  <= '0;
      tid_q   <= '0;
      to_q    <= '0;
      rdata_q <= '0;
      rerr_q  <= '0;
      stray_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mtid_q  <= mtid_d;
      tid_q   <= tid_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      stray_q <= stray_d;
    end
  end

  // Next-state, request/result strobes and stray counting
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    oor_d         = oor_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mtid_d        = mtid_q;
    tid_d         = tid_q;
    to_d          = to_q;
    rdata_d       = rdata_q;
    rerr_d        = rerr_q;
    stray_d       = stray_q;
    cmd_ready     = 1'b0;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    res_valid     = 1'b0;

    if (rsp_valid && state_q != WAIT_RSP && stray_q != 8'hFF)
      stray_d = stray_q + 8'd1;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          wr_d    = cmd_write;
          oor_d   = !cmd_write && cmd_oor;
          state_d = ISSUE;
          // Request bus only moves for requests that will be issued
          if (cmd_write) begin
            addr_d = cmd_addr;
            data_d = cmd_data;
          end else if (!cmd_oor) begin
            addr_d = cmd_addr;
            mtid_d = tid_q;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          mmio_wr_valid = 1'b1;
          state_d       = IDLE;
        end else if (oor_q) begin
          rerr_d  = 2'b11;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          mmio_rd_valid = 1'b1;
          to_d          = '0;
          tid_d         = tid_q + 9'd1;
          state_d       = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          rdata_d = rsp_data;
          rerr_d  = (rsp_tid == mtid_q) ? 2'b00 : 2'b10;
          state_d = DONE;
        end else if (to_q == TO_LAST) begin
          rdata_d = '0;
          rerr_d  = 2'b01;
          state_d = DONE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hc_mmio_initiator.sv
// Bench for hc_mmio_initiator: command table, result scoreboard,
// tid wrap, stray saturation and reset-abandon sequences.
module tb_hc_mmio_initiator;

  localparam int TO = 8;
  localparam int LIMIT = 'h400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_ready;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_data;
  logic        rsp_valid = 1'b0;
  logic [8:0]  rsp_tid = '0;
  logic [63:0] rsp_data = '0;
  logic        res_valid;
  logic [63:0] res_data;
  logic [1:0]  res_err;
  logic [7:0]  stray_cnt;

  hc_mmio_initiator #(.TIMEOUT_CYCLES(TO), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    bit          resp;
    int          dly;
    bit          bad;
    logic [63:0] rdata;
    logic [63:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  vec_t       vecs[10];
  vec_t       v;
  logic [8:0] exp_tid = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wr_valid", 64'(mmio_wr_valid), 64'd0);
    chk("rst_rd_valid", 64'(mmio_rd_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_mmio_addr", 64'(mmio_addr), 64'd0);
    chk("rst_mmio_data", mmio_data, 64'd0);
    chk("rst_mmio_tid", 64'(mmio_tid), 64'd0);
    chk("rst_stray", 64'(stray_cnt), 64'd0);
  endtask

  // Scoreboard: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 64'(res_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_err", 64'(res_err), 64'(e.err));
      end
    end
  end

  task automatic run_cmd(input vec_t c);
    logic [8:0] t;
    chk("ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = c.wr;
    cmd_addr  = c.addr;
    cmd_data  = c.wdata;
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    chk("ready_busy", 64'(cmd_ready), 64'd0);
    if (c.wr) begin
      chk("wr_valid", 64'(mmio_wr_valid), 64'd1);
      chk("wr_no_rd", 64'(mmio_rd_valid), 64'd0);
      chk("wr_addr", 64'(mmio_addr), 64'(c.addr));
      chk("wr_data", mmio_data, c.wdata);
      tick();
      chk("wr_pulse", 64'(mmio_wr_valid), 64'd0);
      chk("wr_ready_back", 64'(cmd_ready), 64'd1);
      chk("wr_addr_hold", 64'(mmio_addr), 64'(c.addr));
      chk("wr_data_hold", mmio_data, c.wdata);
    end else if (32'(c.addr) >= LIMIT) begin
      chk("oor_no_rd", 64'(mmio_rd_valid), 64'd0);
      chk("oor_no_wr", 64'(mmio_wr_valid), 64'd0);
      exp_q.push_back('{c.exp_data, c.exp_err});
      tick();
      chk("oor_res_lat", 64'(res_valid), 64'd1);
      tick();
    end else begin
      t = exp_tid;
      chk("rd_valid", 64'(mmio_rd_valid), 64'd1);
      chk("rd_addr", 64'(mmio_addr), 64'(c.addr));
      chk("rd_tid", 64'(mmio_tid), 64'(t));
      exp_tid = exp_tid + 9'd1;
      exp_q.push_back('{c.exp_data, c.exp_err});
      tick();
      chk("rd_pulse", 64'(mmio_rd_valid), 64'd0);
      if (c.resp) begin
        repeat (c.dly) begin
          chk("rsp_wait", 64'(res_valid), 64'd0);
          tick();
        end
        rsp_valid = 1'b1;
        rsp_tid   = c.bad ? t - 9'd1 : t;
        rsp_data  = c.rdata;
        tick();
        rsp_valid = 1'b0;
        rsp_tid   = '0;
        rsp_data  = '0;
        chk("rsp_res_lat", 64'(res_valid), 64'd1);
      end else begin
        repeat (TO - 1) begin
          chk("to_wait", 64'(res_valid), 64'd0);
          tick();
        end
        chk("to_last_wait", 64'(res_valid), 64'd0);
        tick();
        chk("to_res_lat", 64'(res_valid), 64'd1);
      end
      tick();
    end
  endtask

  function automatic vec_t mk(bit wr, logic [15:0] a, logic [63:0] wd,
                              bit resp, int dly, bit bad,
                              logic [63:0] rd, logic [63:0] ed,
                              logic [1:0] ee);
    vec_t r;
    r.wr = wr; r.addr = a; r.wdata = wd; r.resp = resp;
    r.dly = dly; r.bad = bad; r.rdata = rd;
    r.exp_data = ed; r.exp_err = ee;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1, 'h010, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b00);
    vecs[1] = mk(0, 'h004, 0, 1, 2, 0, 64'h1234, 64'h1234, 2'b00);
    vecs[2] = mk(0, 'h005, 0, 1, 0, 0, 64'hABCD, 64'hABCD, 2'b00);
    vecs[3] = mk(0, 'h400, 0, 0, 0, 0, 0, 0, 2'b11);
    vecs[4] = mk(0, 'h3FF, 0, 1, 1, 1, 64'h55, 64'h55, 2'b10);
    vecs[5] = mk(0, 'h020, 0, 0, 0, 0, 0, 0, 2'b01);
    vecs[6] = mk(0, 'h021, 0, 1, TO - 1, 0, 64'h77, 64'h77, 2'b00);
    vecs[7] = mk(0, 'hFFFF, 0, 0, 0, 0, 0, 0, 2'b11);
    vecs[8] = mk(1, 'h3FF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, 2'b00);
    vecs[9] = mk(0, 'h3FF, 0, 1, 0, 0, 64'hFEED, 64'hFEED, 2'b00);

    tick();
    chk_zero_outs();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);
    chk("stray_after_table", 64'(stray_cnt), 64'd0);

    reset = 1'b1;
    #1;
    chk_zero_outs();
    tick();
    reset = 1'b0;
    exp_tid = '0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("stray_first_cycle", 64'(stray_cnt), 64'd1);

    for (int i = 0; i < 513; i++) begin
      v = mk(0, 16'(i % 'h400), 0, 1, 0, 0, 64'(i), 64'(i), 2'b00);
      run_cmd(v);
    end
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 16'h8, 0, 1, 1, 0, 64'(i + 7), 64'(i + 7), 2'b00);
      run_cmd(v);
    end
    chk("tid_before_bad", 64'(exp_tid), 64'd6);
    v = mk(0, 16'h9, 0, 1, 0, 1, 64'hBAD, 64'hBAD, 2'b10);
    run_cmd(v);
    chk("stray_unchanged", 64'(stray_cnt), 64'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 300; i++) begin
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
      tick();
      if (i == 254) chk("stray_254", 64'(stray_cnt), 64'd254);
      if (i == 255) chk("stray_255", 64'(stray_cnt), 64'd255);
    end
    chk("stray_sat", 64'(stray_cnt), 64'd255);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = 16'h30;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    chk("abandon_rd", 64'(mmio_rd_valid), 64'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk_zero_outs();
    tick();
    reset = 1'b0;
    for (int i = 0; i < TO + 4; i++) begin
      tick();
      chk("abandon_no_res", 64'(res_valid), 64'd0);
    end
    chk("abandon_ready", 64'(cmd_ready), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
